// File: rtl/fpu_pkg.sv
// Shared FPU types and constants: float layout, exponent anchors and rounding-mode
// encodings used by both the int-to-float and float-to-int paths.
package fpu_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } float_t;

    localparam int EXP_BIAS    = 127;
    localparam int EXP_INT_MSB = 158;  // biased exponent of 2^31

    localparam int ROUND_TIES_AWAY = 0;
    localparam int ROUND_TIES_EVEN = 1;

    // Round-up decision from guard, sticky and result LSB.
    function automatic logic round_inc(input logic guard, input logic sticky,
                                       input logic lsb, input int mode);
        if (mode == ROUND_TIES_EVEN)
            return guard & (sticky | lsb);
        return guard;
    endfunction

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter; all_zero flags an all-zero operand,
// in which case count is 0 and must be ignored.
module lzc32 (
    input  logic [31:0] a,
    output logic [4:0]  count,
    output logic        all_zero
);

    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        count    = 5'd0;
        all_zero = 1'b1;
        // Scanning upward lets the highest set bit win.
        for (int i = 0; i < 32; i++) begin
            if (a[i]) begin
                count    = 5'(31 - i);
                all_zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/itof_pipe.sv
// Three-stage signed 32-bit integer to single-precision float converter with a
// single global stall driven by the output handshake.
module itof_pipe
    import fpu_pkg::*;
#(
    parameter int ROUND_MODE = ROUND_TIES_AWAY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y
);

    logic        en;

    logic        v1, s1, z1;
    logic [31:0] a1;

    logic        v2, s2, z2;
    logic [4:0]  l2;
    logic [31:0] n2;

    logic        v3;
    float_t      y3;

    // Whole pipe advances together; a bubble in stage 3 is enough to move.
    assign en        = ~v3 | out_ready;
    assign in_ready  = en;
    assign out_valid = v3;
    assign y         = y3;

    // Stage 1: magnitude as unsigned, so 32'h8000_0000 maps cleanly to 2^31.
    logic [31:0] abs_x;
    assign abs_x = x[31] ? (~x + 32'd1) : x;

    // Stage 2: normalise so the leading one lands in bit 31.
    logic [4:0] lz;
    logic       lz_zero;

    lzc32 u_lzc (
        .a        (a1),
        .count    (lz),
        .all_zero (lz_zero)
    );

    // Stage 3: round the 24-bit significand and pack.
    logic [22:0] frac;
    logic        guard, sticky, inc;
    logic [23:0] sum;
    logic [7:0]  exp_r;
    float_t      packed_y;

    always_comb begin
        frac   = n2[30:8];
        guard  = n2[7];
        sticky = |n2[6:0];
        inc    = round_inc(guard, sticky, frac[0], ROUND_MODE);
        sum    = {1'b0, frac} + {23'd0, inc};
        // A carry out leaves sum[22:0] at zero: the mantissa of the next power of two.
        exp_r  = 8'(EXP_INT_MSB) - {3'd0, l2} + {7'd0, sum[23]};
        if (z2)
            packed_y = '0;
        else
            packed_y = '{sign: s2, exp: exp_r, frac: sum[22:0]};
    end

    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            s1 <= 1'b0;
            z1 <= 1'b0;
            a1 <= '0;
            v2 <= 1'b0;
            s2 <= 1'b0;
            z2 <= 1'b0;
            l2 <= '0;
            n2 <= '0;
            v3 <= 1'b0;
            y3 <= '0;
        end else if (en) begin
            v1 <= in_valid;
            s1 <= x[31];
            z1 <= (x == 32'd0);
            a1 <= abs_x;
            v2 <= v1;
            s2 <= s1;
            z2 <= z1 | lz_zero;
            l2 <= lz;
            n2 <= a1 << lz;
            v3 <= v2;
            y3 <= packed_y;
        end
    end

endmodule

// File: tb/tb_itof_pipe.sv
// Directed and randomised checks of itof_pipe in both rounding modes against an
// arithmetic reference model and hand-computed constants.
module tb_itof_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] x;
    logic        out_ready;

    logic        ir_a, ov_a, ir_e, ov_e;
    logic [31:0] y_a, y_e;

    int errors = 0;
    int checks = 0;

    logic        s_ir_a, s_ov_a, s_ov_e, s_acc;
    logic [31:0] s_y_a, s_y_e;
    logic [31:0] q_a[$];
    logic [31:0] q_e[$];
    int          n_out;

    always #5 clk = ~clk;

    itof_pipe #(.ROUND_MODE(0)) u_away (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a), .x(x),
        .out_valid(ov_a), .out_ready(out_ready), .y(y_a)
    );

    itof_pipe #(.ROUND_MODE(1)) u_even (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_e), .x(x),
        .out_valid(ov_e), .out_ready(out_ready), .y(y_e)
    );

    // Reference: exact magnitude, explicit remainder-vs-half rounding.
    function automatic logic [31:0] ref_conv(input logic [31:0] xi, input bit even);
        longint m, q, r, half;
        int     p, sh;
        bit     up;
        logic [7:0] e;
        if (xi == 32'd0) return 32'd0;
        m = longint'($signed(xi));
        if (m < 0) m = -m;
        p = 0;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        if (p <= 23) begin
            q = m << (23 - p);
        end else begin
            sh   = p - 23;
            q    = m >> sh;
            r    = m - (q << sh);
            half = 64'sd1 << (sh - 1);
            up   = (r > half) || ((r == half) && (!even || q[0]));
            if (up) q = q + 1;
            if (q == (64'sd1 << 24)) begin
                q = 64'sd1 << 23;
                p++;
            end
        end
        e = 8'(127 + p);
        return {xi[31], e, q[22:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive, sample at the falling edge, score transfers, step past the rising edge.
    task automatic cyc(input logic iv, input logic [31:0] xv, input logic ordy);
        logic [31:0] ea, ee;
        in_valid  = iv;
        x         = xv;
        out_ready = ordy;
        @(negedge clk);
        s_ir_a = ir_a;
        s_ov_a = ov_a;
        s_ov_e = ov_e;
        s_y_a  = y_a;
        s_y_e  = y_e;
        s_acc  = iv & ir_a;
        if (rst) begin
            q_a.delete();
            q_e.delete();
        end else begin
            if (ov_a && ordy) begin
                n_out++;
                ea = (q_a.size() != 0) ? q_a.pop_front() : 32'hDEAD_BEEF;
                check("sb_away", y_a, ea);
            end
            if (ov_e && ordy) begin
                ee = (q_e.size() != 0) ? q_e.pop_front() : 32'hDEAD_BEEF;
                check("sb_even", y_e, ee);
            end
            if (iv && ir_a) q_a.push_back(ref_conv(xv, 1'b0));
            if (iv && ir_e) q_e.push_back(ref_conv(xv, 1'b1));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] basic_x[5];
        logic [31:0] basic_y[5];
        logic [31:0] bp_x[4];
        logic        pat[5];
        logic [31:0] xr;
        logic        pend;
        int          base;

        n_out = 0;
        basic_x = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        basic_y = '{32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000, 32'h4F00_0000, 32'hCF00_0000};
        bp_x    = '{32'd100, -32'sd200, 32'd3000000, -32'sd7};
        pat     = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state
        rst = 1'b1;
        cyc(1'b0, 32'd0, 1'b1);
        cyc(1'b0, 32'd0, 1'b1);
        check("rst_out_valid", {31'd0, s_ov_a}, 32'd0);
        check("rst_y", s_y_a, 32'd0);
        check("rst_in_ready", {31'd0, s_ir_a}, 32'd1);
        rst = 1'b0;

        // Basic values back to back, results exactly three cycles later
        for (int k = 0; k < 8; k++) begin
            cyc(k < 5, (k < 5) ? basic_x[k] : 32'd0, 1'b1);
            if (k < 3) begin
                check("basic_early_valid", {31'd0, s_ov_a}, 32'd0);
            end else begin
                check("basic_valid", {31'd0, s_ov_a}, 32'd1);
                check("basic_y_away", s_y_a, basic_y[k-3]);
                check("basic_y_even", s_y_e, basic_y[k-3]);
            end
        end

        // Tie behaviour per rounding mode
        cyc(1'b1, 32'd16777217, 1'b1);
        cyc(1'b1, 32'd16777219, 1'b1);
        cyc(1'b0, 32'd0, 1'b1);
        cyc(1'b0, 32'd0, 1'b1);
        check("tie_away", s_y_a, 32'h4B80_0001);
        check("tie_even", s_y_e, 32'h4B80_0000);
        cyc(1'b0, 32'd0, 1'b1);
        check("tie3_away", s_y_a, 32'h4B80_0002);
        check("tie3_even", s_y_e, 32'h4B80_0002);
        cyc(1'b0, 32'd0, 1'b1);

        // Backpressure: stall five cycles once the pipe is full
        base = n_out;
        for (int k = 0; k < 3; k++) cyc(1'b1, bp_x[k], 1'b1);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, bp_x[3], 1'b0);
            check("bp_out_valid", {31'd0, s_ov_a}, 32'd1);
            check("bp_in_ready", {31'd0, s_ir_a}, 32'd0);
            check("bp_y_stable", s_y_a, ref_conv(bp_x[0], 1'b0));
        end
        cyc(1'b1, bp_x[3], 1'b1);
        check("bp_resume_accept", {31'd0, s_acc}, 32'd1);
        for (int k = 0; k < 4; k++) cyc(1'b0, 32'd0, 1'b1);
        check("bp_out_count", 32'(n_out - base), 32'd4);
        check("bp_queue_empty", 32'(q_a.size()), 32'd0);

        // Bubbles pass through unchanged
        for (int k = 0; k < 8; k++) begin
            cyc((k < 5) ? pat[k] : 1'b0, 32'(k + 5), 1'b1);
            if (k >= 3) check("bubble_valid", {31'd0, s_ov_a}, {31'd0, pat[k-3]});
        end

        // Reset with all three stages occupied
        for (int k = 0; k < 3; k++) cyc(1'b1, 32'd11, 1'b1);
        rst = 1'b1;
        cyc(1'b0, 32'd0, 1'b0);
        rst = 1'b0;
        cyc(1'b1, 32'd12345, 1'b1);
        check("flush_valid", {31'd0, s_ov_a}, 32'd0);
        check("flush_y", s_y_a, 32'd0);
        cyc(1'b0, 32'd0, 1'b1);
        check("flush_valid_2", {31'd0, s_ov_e}, 32'd0);
        cyc(1'b0, 32'd0, 1'b1);
        cyc(1'b0, 32'd0, 1'b1);
        check("post_rst_valid", {31'd0, s_ov_a}, 32'd1);
        check("post_rst_y", s_y_a, 32'h4640_E400);

        // Random operands with random backpressure; upstream holds x until accepted
        pend = 1'b0;
        xr   = 32'd0;
        for (int k = 0; k < 4000; k++) begin
            if (!pend) begin
                case ($urandom_range(0, 3))
                    0: xr = $urandom;
                    1: xr = 32'($urandom_range(0, 511)) - 32'd256;
                    2: xr = $urandom & 32'h8300_01FF;
                    default: xr = 32'h0100_0001 << $urandom_range(0, 6);
                endcase
                pend = ($urandom_range(0, 3) != 0);
            end
            cyc(pend, xr, $urandom_range(0, 3) != 0);
            if (s_acc) pend = 1'b0;
        end
        for (int k = 0; k < 8; k++) cyc(1'b0, 32'd0, 1'b1);
        check("rand_drain_away", 32'(q_a.size()), 32'd0);
        check("rand_drain_even", 32'(q_e.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
